dcache_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage
//  (EX_MEM address/data/MemRead/MemWrite) and off-chip data memory (256-bit line port).

---
 rtl/dcache_controller.sv | 134 +++++++++++++
 tb/tb_dcache_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage
// and a 256-bit line-wide data memory. Hits complete in the request cycle; misses stall.
module dcache_controller #(
   parameter int TAG_W   = 22,
   parameter int INDEX_W = 5,
   parameter int LINE_W  = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       p1_addr_i,
   input  logic [31:0]       p1_data_i,
   input  logic              p1_MemRead_i,
   input  logic              p1_MemWrite_i,
   output logic [31:0]       p1_data_o,
   output logic              p1_stall_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o
);

   localparam int LINES  = 1 << INDEX_W;
   localparam int OFFS_W = 32 - TAG_W - INDEX_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

   state_t state, state_nx;

   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [LINE_W-1:0] data_mem [LINES];
   logic [LINES-1:0]  valid;
   logic [LINES-1:0]  dirty;

   logic [INDEX_W-1:0] cap_idx;
   logic [TAG_W-1:0]   cap_tag;

   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic [OFFS_W-3:0]  word_sel;
   logic               req;
   logic               hit;
   logic               write_hit;
   logic               miss_start;
   logic               refill_done;
   logic               unused_addr_bits;

   assign req_idx          = p1_addr_i[OFFS_W +: INDEX_W];
   assign req_tag          = p1_addr_i[31 -: TAG_W];
   assign word_sel         = p1_addr_i[OFFS_W-1:2];
   assign unused_addr_bits = ^p1_addr_i[1:0];
   assign req              = p1_MemRead_i | p1_MemWrite_i;
   assign hit              = valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign refill_done      = (state == ALLOCATE) && mem_ack_i;

   always_comb begin
      state_nx     = state;
      p1_stall_o   = 1'b0;
      p1_data_o    = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      write_hit    = 1'b0;
      miss_start   = 1'b0;
      case (state)
         IDLE: begin
            if (req && hit) begin
               // Simultaneous read and write is treated as a write: no load data.
               if (p1_MemWrite_i) write_hit = 1'b1;
               else               p1_data_o = data_mem[req_idx][{word_sel, 5'b0} +: 32];
            end else if (req) begin
               p1_stall_o = 1'b1;
               miss_start = 1'b1;
               state_nx   = (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            p1_stall_o   = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {tag_mem[cap_idx], cap_idx, {OFFS_W{1'b0}}};
            mem_data_o   = data_mem[cap_idx];
            if (mem_ack_i) state_nx = ALLOCATE;
         end
         ALLOCATE: begin
            p1_stall_o   = 1'b1;
            mem_enable_o = 1'b1;
            mem_addr_o   = {cap_tag, cap_idx, {OFFS_W{1'b0}}};
            if (mem_ack_i) state_nx = REFILL;
         end
         REFILL: begin
            p1_stall_o = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid <= '0;
         dirty <= '0;
      end else if (write_hit) begin
         dirty[req_idx] <= 1'b1;
      end else if (refill_done) begin
         valid[cap_idx] <= 1'b1;
         dirty[cap_idx] <= 1'b0;
      end
   end

   // Index and tag are frozen at the miss so a misbehaving CPU cannot redirect the fill.
   always_ff @(posedge clk_i) begin
      if (miss_start) begin
         cap_idx <= req_idx;
         cap_tag <= req_tag;
      end
   end

   always_ff @(posedge clk_i) begin
      if (write_hit) data_mem[req_idx][{word_sel, 5'b0} +: 32] <= p1_data_i;
      if (refill_done) begin
         data_mem[cap_idx] <= mem_data_i;
         tag_mem[cap_idx]  <= cap_tag;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomised bench for dcache_controller: a line-level cache/memory model predicts hits,
// evictions, memory transactions, stall length and load data for every access.
module tb_dcache_controller;

   logic         clk = 1'b0;
   logic         rst_i;
   logic [31:0]  p1_addr_i, p1_data_i, p1_data_o, mem_addr_o;
   logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
   logic [255:0] mem_data_i, mem_data_o;
   logic         mem_ack_i, mem_enable_o, mem_write_o;

   dcache_controller dut (
      .clk_i(clk), .rst_i(rst_i),
      .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
      .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
      .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Memory side: mem_store is what the DUT sees, gold is the model's private copy.
   logic [255:0] mem_store [bit [26:0]];
   logic [255:0] gold      [bit [26:0]];
   int           mem_delay = 1;
   int           resp_cnt  = 0;
   int           en_cycles = 0;
   int           unstable  = 0;
   logic [31:0]  f_addr;
   logic         f_wr;
   logic [255:0] f_data;
   logic [31:0]  q_addr [$];
   logic         q_wr   [$];
   logic [255:0] q_data [$];

   // Reference cache state.
   bit           mv [32];
   bit           md [32];
   logic [21:0]  mt [32];
   logic [255:0] ml [32];

   logic [31:0]  last_rdata;
   logic [255:0] last_wb_data;

   function automatic logic [255:0] init_line(input bit [26:0] la);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = {la, 3'(i), 2'b01};
      return l;
   endfunction

   function automatic logic [255:0] store_rd(input bit [26:0] la);
      if (mem_store.exists(la)) return mem_store[la];
      return init_line(la);
   endfunction

   function automatic logic [255:0] gold_rd(input bit [26:0] la);
      if (gold.exists(la)) return gold[la];
      return init_line(la);
   endfunction

   initial begin
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      forever begin
         @(negedge clk);
         mem_ack_i = 1'b0;
         if (rst_i || !mem_enable_o) begin
            resp_cnt = 0;
         end else begin
            en_cycles++;
            if (resp_cnt == 0) begin
               f_addr = mem_addr_o; f_wr = mem_write_o; f_data = mem_data_o;
            end else if (f_addr !== mem_addr_o || f_wr !== mem_write_o ||
                         (f_wr && f_data !== mem_data_o)) begin
               unstable++;
            end
            resp_cnt++;
            if (resp_cnt >= mem_delay) begin
               mem_ack_i = 1'b1;
               if (mem_write_o) mem_store[mem_addr_o[31:5]] = mem_data_o;
               else             mem_data_i = store_rd(mem_addr_o[31:5]);
               q_addr.push_back(mem_addr_o);
               q_wr.push_back(mem_write_o);
               q_data.push_back(mem_data_o);
               resp_cnt = 0;
            end
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         mv[i] = 1'b0;
         md[i] = 1'b0;
      end
   endtask

   task automatic access(input logic [31:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, input int dly, input string name);
      logic [4:0]   idx;
      logic [21:0]  tg;
      logic [2:0]   w;
      bit           miss, exp_wb;
      int           exp_ntx, exp_stall, n, k;
      logic [31:0]  exp_wb_addr, exp_rdata;
      logic [255:0] exp_wb_data;
      idx = a[9:5]; tg = a[31:10]; w = a[4:2];
      miss = (rd || wr) && !(mv[idx] && mt[idx] == tg);
      exp_wb = 1'b0; exp_wb_addr = '0; exp_wb_data = '0;
      if (miss) begin
         if (mv[idx] && md[idx]) begin
            exp_wb      = 1'b1;
            exp_wb_addr = {mt[idx], idx, 5'b0};
            exp_wb_data = ml[idx];
            gold[{mt[idx], idx}] = ml[idx];
         end
         ml[idx] = gold_rd(a[31:5]);
         mt[idx] = tg; mv[idx] = 1'b1; md[idx] = 1'b0;
      end
      exp_rdata = '0;
      if (wr) begin
         ml[idx][w*32 +: 32] = d;
         md[idx] = 1'b1;
      end else if (rd) begin
         exp_rdata = ml[idx][w*32 +: 32];
      end
      exp_ntx   = miss ? (exp_wb ? 2 : 1) : 0;
      exp_stall = miss ? 2 + dly * exp_ntx : 0;

      q_addr.delete(); q_wr.delete(); q_data.delete();
      en_cycles = 0; unstable = 0; mem_delay = dly;
      @(negedge clk);
      p1_addr_i = a; p1_data_i = d; p1_MemRead_i = rd; p1_MemWrite_i = wr;
      #1;
      n = 0;
      while (p1_stall_o === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
         #1;
      end
      last_rdata = p1_data_o;

      checks++;
      if (n !== exp_stall) $display("FAIL %s stall_cycles: got %0d want %0d", name, n, exp_stall);
      else passed++;
      checks++;
      if (p1_data_o !== exp_rdata) $display("FAIL %s rdata: got %h want %h", name, p1_data_o, exp_rdata);
      else passed++;
      checks++;
      if (mem_enable_o !== 1'b0) $display("FAIL %s enable_after: got %b want 0", name, mem_enable_o);
      else passed++;
      checks++;
      if (q_addr.size() !== exp_ntx) $display("FAIL %s txn_count: got %0d want %0d", name, q_addr.size(), exp_ntx);
      else passed++;
      checks++;
      if (en_cycles !== dly * exp_ntx) $display("FAIL %s enable_cycles: got %0d want %0d", name, en_cycles, dly * exp_ntx);
      else passed++;
      checks++;
      if (unstable !== 0) $display("FAIL %s handshake_stable: got %0d changes want 0", name, unstable);
      else passed++;
      if (q_addr.size() == exp_ntx && exp_ntx > 0) begin
         k = 0;
         if (exp_wb) begin
            last_wb_data = q_data[0];
            checks++;
            if (q_wr[0] !== 1'b1 || q_addr[0] !== exp_wb_addr)
               $display("FAIL %s wb_req: got wr=%b addr=%h want wr=1 addr=%h", name, q_wr[0], q_addr[0], exp_wb_addr);
            else passed++;
            checks++;
            if (q_data[0] !== exp_wb_data) $display("FAIL %s wb_data: got %h want %h", name, q_data[0], exp_wb_data);
            else passed++;
            k = 1;
         end
         checks++;
         if (q_wr[k] !== 1'b0 || q_addr[k] !== {tg, idx, 5'b0})
            $display("FAIL %s alloc_req: got wr=%b addr=%h want wr=0 addr=%h", name, q_wr[k], q_addr[k], {tg, idx, 5'b0});
         else passed++;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      #1;
      model_reset();
      checks++;
      if (p1_stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", p1_stall_o); else passed++;
      checks++;
      if (mem_enable_o !== 1'b0) $display("FAIL reset_enable: got %b want 0", mem_enable_o); else passed++;
      checks++;
      if (mem_write_o !== 1'b0) $display("FAIL reset_write: got %b want 0", mem_write_o); else passed++;
      checks++;
      if (p1_data_o !== 32'h0) $display("FAIL reset_data: got %h want 0", p1_data_o); else passed++;
   endtask

   task automatic test_cold_read_miss();
      access(32'h44, 32'h0, 1'b1, 1'b0, 3, "t1_cold_miss");
      checks++;
      if (last_rdata !== 32'hDEADBEEF) $display("FAIL t1_deadbeef: got %h want deadbeef", last_rdata);
      else passed++;
   endtask

   task automatic test_write_read_hit();
      access(32'h48, 32'h12345678, 1'b0, 1'b1, 2, "t2_write_hit");
      access(32'h48, 32'h0, 1'b1, 1'b0, 2, "t2_read_hit");
      checks++;
      if (last_rdata !== 32'h12345678) $display("FAIL t2_readback: got %h want 12345678", last_rdata);
      else passed++;
   endtask

   task automatic test_dirty_evict();
      last_wb_data = '0;
      access(32'h440, 32'h0, 1'b1, 1'b0, 2, "t3_dirty_evict");
      checks++;
      if (last_wb_data[95:64] !== 32'h12345678) $display("FAIL t3_wb_word: got %h want 12345678", last_wb_data[95:64]);
      else passed++;
   endtask

   task automatic test_clean_evict();
      access(32'h48, 32'h0, 1'b1, 1'b0, 4, "t4_clean_evict");
      checks++;
      if (last_rdata !== 32'h12345678) $display("FAIL t4_memcopy: got %h want 12345678", last_rdata);
      else passed++;
   endtask

   task automatic test_read_write_both();
      access(32'h48, 32'hCAFEF00D, 1'b1, 1'b1, 1, "t6_both_req");
      access(32'h48, 32'h0, 1'b1, 1'b0, 1, "t6_readback");
      checks++;
      if (last_rdata !== 32'hCAFEF00D) $display("FAIL t6_written: got %h want cafef00d", last_rdata);
      else passed++;
      last_wb_data = '0;
      access(32'h440, 32'h0, 1'b1, 1'b0, 1, "t6_dirty_evict");
      checks++;
      if (last_wb_data[95:64] !== 32'hCAFEF00D) $display("FAIL t6_dirty: got %h want cafef00d", last_wb_data[95:64]);
      else passed++;
   endtask

   task automatic test_reset_mid_alloc();
      mem_delay = 50;
      q_addr.delete(); q_wr.delete(); q_data.delete();
      @(negedge clk);
      p1_addr_i = 32'h1A0; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0)
         $display("FAIL t5_in_alloc: got en=%b wr=%b want en=1 wr=0", mem_enable_o, mem_write_o);
      else passed++;
      @(negedge clk);
      rst_i = 1'b1; p1_MemRead_i = 1'b0;
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      model_reset();
      checks++;
      if (mem_enable_o !== 1'b0 || p1_stall_o !== 1'b0)
         $display("FAIL t5_after_reset: got en=%b stall=%b want 0 0", mem_enable_o, p1_stall_o);
      else passed++;
      checks++;
      if (q_addr.size() !== 0) $display("FAIL t5_dropped: got %0d acks want 0", q_addr.size());
      else passed++;
      access(32'h44, 32'h0, 1'b1, 1'b0, 2, "t5_remiss");
   endtask

   task automatic test_random();
      logic [31:0] a;
      int          mode;
      for (int i = 0; i < 150; i++) begin
         a    = {22'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         mode = $urandom_range(0, 3);
         access(a, $urandom, mode[0], mode[1], $urandom_range(1, 4), "rand");
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [255:0] l;
      l = init_line(27'h2);
      l[63:32] = 32'hDEADBEEF;
      mem_store[27'h2] = l;
      gold[27'h2]      = l;
      test_reset();
      test_cold_read_miss();
      test_write_read_hit();
      test_dirty_evict();
      test_clean_evict();
      test_read_write_both();
      test_reset_mid_alloc();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
